// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the CP0-side interrupt controller.
package int_ctrl_pkg;

    localparam int unsigned NUM_IRQ_DEFAULT = 6;
    localparam int unsigned ADDR_W          = 2;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ID_W            = 3;

    localparam logic [DATA_W-1:0] CTRL_ID_DEFAULT = 32'h494E5401;

    localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_PEND = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_ID   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

endpackage

// File: rtl/int_ctrl_if.sv
// Config side-bus and CP0 handshake signals of the interrupt controller.
interface int_ctrl_if #(
    parameter int unsigned NUM_IRQ = int_ctrl_pkg::NUM_IRQ_DEFAULT
);
    import int_ctrl_pkg::*;

    logic                i_cfg_we;
    logic [ADDR_W-1:0]   i_cfg_addr;
    logic [DATA_W-1:0]   i_cfg_wdata;
    logic [DATA_W-1:0]   o_cfg_rdata;
    logic                i_answer_exc;
    logic                i_is_eret;
    logic [NUM_IRQ-1:0]  o_int;
    logic                o_busy;
    logic [ID_W-1:0]     o_irq_id;

    modport master (
        output i_cfg_we, i_cfg_addr, i_cfg_wdata, i_answer_exc, i_is_eret,
        input  o_cfg_rdata, o_int, o_busy, o_irq_id
    );

    modport slave (
        input  i_cfg_we, i_cfg_addr, i_cfg_wdata, i_answer_exc, i_is_eret,
        output o_cfg_rdata, o_int, o_busy, o_irq_id
    );

endinterface

// File: rtl/int_src_cond.sv
// One interrupt line: optional 2-flop synchronizer (INT_CTRL_SYNC_EN), edge detect, pending bit.
module int_src_cond (
    input  logic clk,
    input  logic resetn,
    input  logic i_irq,
    input  logic i_bypass,
    input  logic i_edge,
    input  logic i_clr,
    output logic o_pending
);

    logic irq_s;
    logic src;
    logic prev_q;

`ifdef INT_CTRL_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_irq;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = i_irq;
`endif

    // The bypass input (timer) joins after the synchronizer.
    assign src = irq_s | i_bypass;

    // A new rising edge beats a simultaneous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q    <= 1'b0;
            o_pending <= 1'b0;
        end else begin
            prev_q <= src;
            if (i_edge) o_pending <= (src & ~prev_q) | (o_pending & ~i_clr);
            else        o_pending <= src;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller in front of CP0: latch, mask, prioritise, present one line until answered.
// Build option INT_CTRL_SYNC_EN adds a 2-flop synchronizer on every i_irq bit.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned       NUM_IRQ = NUM_IRQ_DEFAULT,
    parameter logic [DATA_W-1:0] CTRL_ID = CTRL_ID_DEFAULT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_timer_int,
    int_ctrl_if.slave          cp0
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d, win_id;
    logic [NUM_IRQ-1:0] int_q, int_d;
    logic [NUM_IRQ-1:0] mask_q, edge_q, pending, eligible, bypass, w1c, clr;
    logic               win_any, accept;
    logic               unused_wdata;

    assign bypass       = {i_timer_int, {(NUM_IRQ-1){1'b0}}};
    assign eligible     = pending & mask_q;
    assign unused_wdata = ^cp0.i_cfg_wdata[DATA_W-1:NUM_IRQ];
    assign w1c = (cp0.i_cfg_we && cp0.i_cfg_addr == ADDR_PEND) ?
                 cp0.i_cfg_wdata[NUM_IRQ-1:0] : '0;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        int_src_cond u_cond (
            .clk       (clk),
            .resetn    (resetn),
            .i_irq     (i_irq[g]),
            .i_bypass  (bypass[g]),
            .i_edge    (edge_q[g]),
            .i_clr     (clr[g]),
            .o_pending (pending[g])
        );
    end

    // Highest eligible index wins, so the timer line goes first.
    always_comb begin
        win_any = |eligible;
        win_id  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i]) win_id = ID_W'(i);
        end
    end

    always_comb begin
        clr = w1c;
        if (accept) clr[id_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    id_d    = win_id;
                    state_d = ST_ASSERT;
                end
            end
            // CP0 answering wins over a request withdrawn in the same cycle.
            ST_ASSERT: begin
                if (cp0.i_answer_exc) begin
                    accept  = 1'b1;
                    state_d = ST_SERVICE;
                end else if (!eligible[id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: if (cp0.i_is_eret) state_d = ST_HOLDOFF;
            ST_HOLDOFF: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        int_d = (state_d == ST_ASSERT) ? (NUM_IRQ'(1) << id_d) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            int_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            int_q   <= int_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mask_q <= '0;
            edge_q <= '0;
        end else if (cp0.i_cfg_we) begin
            if (cp0.i_cfg_addr == ADDR_MASK) mask_q <= cp0.i_cfg_wdata[NUM_IRQ-1:0];
            if (cp0.i_cfg_addr == ADDR_EDGE) edge_q <= cp0.i_cfg_wdata[NUM_IRQ-1:0];
        end
    end

    always_comb begin
        cp0.o_cfg_rdata = '0;
        case (cp0.i_cfg_addr)
            ADDR_MASK: cp0.o_cfg_rdata = DATA_W'(mask_q);
            ADDR_EDGE: cp0.o_cfg_rdata = DATA_W'(edge_q);
            ADDR_PEND: cp0.o_cfg_rdata = DATA_W'(pending);
            ADDR_ID:   cp0.o_cfg_rdata = CTRL_ID;
            default:   cp0.o_cfg_rdata = '0;
        endcase
    end

    assign cp0.o_int    = int_q;
    assign cp0.o_busy   = (state_q != ST_IDLE);
    assign cp0.o_irq_id = id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_int_ctrl;

    localparam logic [31:0] ID_VAL = 32'h494E5401;

    logic       clk = 1'b0;
    logic       resetn;
    logic [5:0] irq;
    logic       tmr;

    int_ctrl_if #(.NUM_IRQ(6)) bus ();

    int_ctrl #(.NUM_IRQ(6), .CTRL_ID(ID_VAL)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_irq       (irq),
        .i_timer_int (tmr),
        .cp0         (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  oi;
        logic        bz;
        logic [2:0]  id;
        logic [31:0] rd;
        bit          so;
        logic [5:0]  s_oi;
        logic        s_bz;
        logic [2:0]  s_id;
        bit          sr;
        logic [31:0] s_rd;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: what the controller is doing, not how.
    localparam int P_IDLE = 0, P_PRESENT = 1, P_SERVICE = 2, P_HOLD = 3;
    int         m_phase;
    int         m_cur;
    logic [5:0] m_mask, m_edge, m_pend, m_prev, m_s1, m_s2;

    // Inputs currently applied to the DUT.
    logic        c_rn, c_tmr, c_we, c_ans, c_er;
    logic [5:0]  c_irq;
    logic [1:0]  c_addr;
    logic [31:0] c_wd;

    bit          sp_on = 0, sp_rd_on = 0;
    logic [5:0]  sp_oi;
    logic        sp_bz;
    logic [2:0]  sp_id;
    logic [31:0] sp_rd;

    function automatic int top_bit(input logic [5:0] v);
        int r = -1;
        for (int i = 0; i < 6; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_cur = 0;
        m_mask = '0; m_edge = '0; m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
    endtask

    task automatic model_step();
        logic [5:0] src, elig, clrv, rise;
        int         n_phase, n_cur;
        bit         taken;
        if (!c_rn) begin
            model_reset();
            return;
        end
`ifdef INT_CTRL_SYNC_EN
        src = m_s2;
`else
        src = c_irq;
`endif
        src[5] = src[5] | c_tmr;
        elig    = m_pend & m_mask;
        n_phase = m_phase;
        n_cur   = m_cur;
        taken   = 0;
        if (m_phase == P_IDLE) begin
            if (elig != 0) begin n_cur = top_bit(elig); n_phase = P_PRESENT; end
        end else if (m_phase == P_PRESENT) begin
            if (c_ans) begin n_phase = P_SERVICE; taken = 1; end
            else if (!elig[m_cur]) n_phase = P_IDLE;
        end else if (m_phase == P_SERVICE) begin
            if (c_er) n_phase = P_HOLD;
        end else begin
            n_phase = P_IDLE;
        end
        clrv = (c_we && c_addr == 2'd2) ? c_wd[5:0] : 6'd0;
        if (taken) clrv[m_cur] = 1'b1;
        rise = src & ~m_prev;
        for (int i = 0; i < 6; i++)
            m_pend[i] = m_edge[i] ? (rise[i] || (m_pend[i] && !clrv[i])) : src[i];
        if (c_we && c_addr == 2'd0) m_mask = c_wd[5:0];
        if (c_we && c_addr == 2'd1) m_edge = c_wd[5:0];
        m_prev  = src;
        m_s2    = m_s1;
        m_s1    = c_irq;
        m_phase = n_phase;
        m_cur   = n_cur;
    endtask

    task automatic spot_out(input logic [5:0] oi, input logic bz, input logic [2:0] id);
        sp_on = 1; sp_oi = oi; sp_bz = bz; sp_id = id;
    endtask

    task automatic spot_rd(input logic [31:0] rd);
        sp_rd_on = 1; sp_rd = rd;
    endtask

    // One clock: advance the model over the edge, apply new inputs, queue the expectation.
    task automatic cyc(input logic rn, input logic [5:0] ir, input logic tm, input logic we,
                       input logic [1:0] ad, input logic [31:0] wd, input logic an, input logic er);
        exp_t e;
        @(posedge clk);
        #1;
        model_step();
        c_rn = rn; c_irq = ir; c_tmr = tm; c_we = we; c_addr = ad; c_wd = wd; c_ans = an; c_er = er;
        resetn = rn; irq = ir; tmr = tm;
        bus.i_cfg_we = we; bus.i_cfg_addr = ad; bus.i_cfg_wdata = wd;
        bus.i_answer_exc = an; bus.i_is_eret = er;
        if (!rn) model_reset();
        e.oi = (m_phase == P_PRESENT) ? (6'b1 << m_cur) : 6'd0;
        e.bz = (m_phase != P_IDLE);
        e.id = 3'(m_cur);
        case (ad)
            2'd0:    e.rd = {26'd0, m_mask};
            2'd1:    e.rd = {26'd0, m_edge};
            2'd2:    e.rd = {26'd0, m_pend};
            default: e.rd = ID_VAL;
        endcase
`ifdef INT_CTRL_SYNC_EN
        e.so = 0; e.sr = 0;
`else
        e.so = sp_on; e.sr = sp_rd_on;
`endif
        e.s_oi = sp_oi; e.s_bz = sp_bz; e.s_id = sp_id; e.s_rd = sp_rd;
        sp_on = 0; sp_rd_on = 0;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("o_int",    32'(bus.o_int),    32'(e.oi));
                chk("o_busy",   32'(bus.o_busy),   32'(e.bz));
                chk("o_irq_id", 32'(bus.o_irq_id), 32'(e.id));
                chk("rdata",    bus.o_cfg_rdata,   e.rd);
                if (e.so) begin
                    chk("plan_o_int",  32'(bus.o_int),    32'(e.s_oi));
                    chk("plan_o_busy", 32'(bus.o_busy),   32'(e.s_bz));
                    chk("plan_irq_id", 32'(bus.o_irq_id), 32'(e.s_id));
                end
                if (e.sr) chk("plan_rdata", bus.o_cfg_rdata, e.s_rd);
            end
        end
    end

    initial begin
        logic [5:0] r_irq;
        logic       r_tmr;
        resetn = 1'b0; irq = '0; tmr = 1'b0;
        bus.i_cfg_we = 1'b0; bus.i_cfg_addr = '0; bus.i_cfg_wdata = '0;
        bus.i_answer_exc = 1'b0; bus.i_is_eret = 1'b0;
        c_rn = 0; c_irq = '0; c_tmr = 0; c_we = 0; c_addr = '0; c_wd = '0; c_ans = 0; c_er = 0;
        model_reset();

        spot_out(6'd0, 1'b0, 3'd0); spot_rd(ID_VAL);
        cyc(0, 6'd0, 0, 0, 2'd3, 0, 0, 0);
        spot_rd(32'd0);
        cyc(0, 6'd0, 0, 0, 2'd0, 0, 0, 0);

        // Level line 2: present, answer, eret, re-present while still high.
        cyc(1, 6'd0, 0, 1, 2'd0, 32'h3F, 0, 0);
        cyc(1, 6'd0, 0, 1, 2'd1, 32'h00, 0, 0);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 0, 0);
        spot_out(6'h04, 1'b1, 3'd2);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 1, 0);
        spot_out(6'h00, 1'b1, 3'd2);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 0, 1);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 0, 0);
        spot_out(6'h00, 1'b0, 3'd2);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 0, 0);
        spot_out(6'h04, 1'b1, 3'd2);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 1, 0);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 1);
        repeat (3) cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);

        // Edge line 0: one-cycle pulse, accepted, pending cleared on answer.
        cyc(1, 6'h00, 0, 1, 2'd1, 32'h01, 0, 0);
        cyc(1, 6'h00, 0, 1, 2'd0, 32'h01, 0, 0);
        cyc(1, 6'h01, 0, 0, 2'd2, 0, 0, 0);
        spot_rd(32'h01);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);
        spot_out(6'h01, 1'b1, 3'd0); spot_rd(32'h01);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 1, 0);
        spot_out(6'h00, 1'b1, 3'd0); spot_rd(32'h00);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 1);
        repeat (2) cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);

        // Timer plus lines 0/1 together: timer line 5 wins.
        cyc(1, 6'h00, 0, 1, 2'd1, 32'h00, 0, 0);
        cyc(1, 6'h00, 0, 1, 2'd0, 32'h3F, 0, 0);
        cyc(1, 6'h03, 1, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h03, 1, 0, 2'd2, 0, 0, 0);
        spot_out(6'h20, 1'b1, 3'd5);
        cyc(1, 6'h03, 1, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 1, 0);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 1);
        repeat (3) cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);

        // W1C of the presented edge line before answer withdraws it.
        cyc(1, 6'h00, 0, 1, 2'd1, 32'h01, 0, 0);
        cyc(1, 6'h01, 0, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);
        spot_out(6'h01, 1'b1, 3'd0);
        cyc(1, 6'h00, 0, 1, 2'd2, 32'h01, 0, 0);
        spot_out(6'h01, 1'b1, 3'd0); spot_rd(32'h00);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);
        spot_out(6'h00, 1'b0, 3'd0);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);

        // Edge set and W1C in the same cycle: set wins.
        cyc(1, 6'h00, 0, 1, 2'd0, 32'h00, 0, 0);
        cyc(1, 6'h01, 0, 1, 2'd2, 32'h01, 0, 0);
        spot_rd(32'h01);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h00, 0, 1, 2'd2, 32'h01, 0, 0);
        spot_rd(32'h00);
        cyc(1, 6'h00, 0, 0, 2'd2, 0, 0, 0);

        // Reset while in service.
        cyc(1, 6'h00, 0, 1, 2'd0, 32'h3F, 0, 0);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 0, 0);
        spot_out(6'h04, 1'b1, 3'd2);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 0, 0);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 1, 0);
        spot_out(6'h00, 1'b1, 3'd2);
        cyc(1, 6'h04, 0, 0, 2'd2, 0, 0, 0);
        spot_out(6'h00, 1'b0, 3'd0); spot_rd(32'h0);
        cyc(0, 6'h04, 0, 0, 2'd0, 0, 0, 0);
        spot_rd(32'h0);
        cyc(0, 6'h00, 0, 0, 2'd1, 0, 0, 0);
        spot_rd(32'h0);
        cyc(0, 6'h00, 0, 0, 2'd2, 0, 0, 0);
        spot_rd(ID_VAL);
        cyc(0, 6'h00, 0, 0, 2'd3, 0, 0, 0);
        cyc(1, 6'h00, 0, 0, 2'd0, 0, 0, 0);

        // Random traffic.
        r_irq = '0; r_tmr = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            logic       we, an, er, rn;
            logic [1:0] ad;
            for (int b = 0; b < 6; b++)
                if ($urandom_range(7) == 0) r_irq[b] = ~r_irq[b];
            if ($urandom_range(15) == 0) r_tmr = ~r_tmr;
            we = ($urandom_range(5) == 0);
            ad = 2'($urandom_range(3));
            an = ($urandom_range(2) == 0);
            er = ($urandom_range(3) == 0);
            rn = ($urandom_range(499) != 0);
            cyc(rn, r_irq, r_tmr, we, ad, $urandom, an, er);
        end

        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller in front of CP0. Collects the 6 hardware interrupt sources and the CP0 timer interrupt, then latches, masks and prioritises them.
- Presents exactly one interrupt at a time on CP0's interrupt input and holds it until CP0 answers.
- Tracks the in-service interrupt until eret.
- Software configures it through a small register port on the MFC0/MTC0 side bus.

Parameters:
- NUM_IRQ, 6, number of interrupt lines (matches CP0 Cause[15:10]).
- CTRL_ID, 32'h494E5401, read-only identification value.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- i_irq  in  NUM_IRQ  raw external interrupt requests
- i_timer_int  in  1  CP0 timer interrupt; ORed onto line NUM_IRQ-1
- i_cfg_we  in  1  config write strobe
- i_cfg_addr  in  2  config register address
- i_cfg_wdata  in  32  config write data
- o_cfg_rdata  out  32  config read data, combinational on i_cfg_addr
- i_answer_exc  in  1  CP0 o_answer_exc
- i_is_eret  in  1  eret retiring this cycle
- o_int  out  NUM_IRQ  one-hot interrupt to CP0 i_int
- o_busy  out  1  FSM not IDLE
- o_irq_id  out  3  index of presented/in-service line

Behaviour:
- Registers:
  - addr0 MASK, RW, reset 0; bit=1 enables the line.
  - addr1 EDGE, RW, reset 0; 1=edge, 0=level.
  - addr2 PENDING, read; write-1-to-clear on edge lines only.
  - addr3 ID, RO = CTRL_ID.
  - Unused upper bits read 0.
- Source: src = i_irq, with bit NUM_IRQ-1 ORed with i_timer_int.
- Pending, level line: pending[i] <= src[i] every cycle.
- Pending, edge line: set on src[i] rising edge (previous-sample register, reset 0). Cleared by W1C or by acceptance.
- Set and clear in the same cycle: set wins.
- Eligible = pending & MASK. Priority: highest index wins (timer line first).
- FSM, reset IDLE:
  - IDLE: if eligible != 0, latch winner into id and go to ASSERT.
  - ASSERT: o_int = one-hot(id). When i_answer_exc=1, go to SERVICE and clear pending[id] if it is an edge line.
  - ASSERT, pending[id] drops before answer (level deassert, W1C, or MASK cleared): return to IDLE and drop o_int the same cycle it is registered.
  - SERVICE: o_int = 0, wait for i_is_eret, then go to HOLDOFF.
  - HOLDOFF: 1 cycle so CP0 EXL clears, then go to IDLE.
- o_int is nonzero only in ASSERT. o_int is registered from state; never more than one bit set.
- Latency, no sync: src edge in cycle N, pending in N+1, o_int in N+2.
- i_is_eret outside SERVICE: ignored.
- Config writes are allowed in any state; they take effect the next cycle.
- Reset values: o_int=0, o_busy=0, o_irq_id=0, state=IDLE, all registers 0 except ID. Reset mid-operation aborts immediately.

Optional Feature:
- INT_CTRL_SYNC_EN defined: each i_irq bit passes through a 2-flop synchronizer (reset 0) before edge/level logic; latency +2 cycles. i_timer_int is not synchronized.
- Undefined: i_irq is sampled directly.

Decomposition:
- Package int_ctrl_pkg holds:
  - FSM state encoding (IDLE, ASSERT, SERVICE, HOLDOFF)
  - register address constants
  - CTRL_ID
  - NUM_IRQ default
- One sub-module, int_src_cond: per-line synchronizer (under the macro) plus edge detector plus pending bit; instantiated NUM_IRQ times.

Test Plan:
- MASK=0x3F, EDGE=0, hold i_irq=6'b000100 → o_int=6'b000100 two cycles later; assert i_answer_exc → o_int=0, state SERVICE; pulse i_is_eret → o_busy=0 after HOLDOFF; o_int re-asserts while the level is still high.
- EDGE=0x01, MASK=0x01, 1-cycle pulse on i_irq[0] → PENDING reads 0x01, o_int=0x01; after answer PENDING reads 0x00.
- i_irq=6'b000011 and i_timer_int=1 simultaneously, MASK=0x3F → o_int=6'b100000, o_irq_id=5.
- Edge line pending in ASSERT, write PENDING=0x01 before answer → o_int drops, FSM returns to IDLE, no service.
- Edge pulse in the same cycle as a W1C write to that bit → PENDING stays 1.
- resetn low during SERVICE → all outputs 0, MASK/EDGE/PENDING read 0, ID reads 0x494E5401.
